// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_controller
//  Purpose  : Moore-style control FSM for a multicycle RV32I-subset datapath.
//             Sequences fetch, decode, memory, ALU, branch and jump states,
//             supervises memory handshakes with a wait-cycle timeout and
//             latches a terminal fault.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TIMEOUT    : consecutive MemReady-less request cycles before fault (1..255)
//  Build macro
//    ILLEGAL_TRAP_EN : when defined, unknown opcodes in DECODE enter FAULT;
//                      otherwise they retire as a NOP back to FETCH.
//  Ports
//    clk, rst_n        : clock (rising edge), async active-low reset
//    Instr[31:0]       : instruction register (opcode [6:0], funct3 [14:12])
//    Zero              : ALU zero flag
//    MemReady          : memory completion strobe
//    MemReq, MemWrite  : memory request / store qualifier
//    IRWrite, PCWrite  : instruction register / PC write enables
//    AdrSrc            : address select (0 PC, 1 ALUOut)
//    RegWrite          : register file write
//    ResultSrc[1:0]    : 00 ALUOut, 01 data, 10 ALUResult
//    ALUSrcA[1:0]      : 00 PC, 01 OldPC, 10 rs1
//    ALUSrcB[1:0]      : 00 rs2, 01 ImmExt, 10 constant 4
//    ALUOp[1:0]        : 00 add, 01 sub/compare, 10 funct-decoded
//    ImmSrc[2:0]       : 000 I, 001 S, 010 B, 011 J
//    State[3:0]        : current state encoding
//    Fault             : sticky fault flag
// ============================================================================
module multicycle_controller #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        MemReq,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [2:0]  ImmSrc,
  output logic [3:0]  State,
  output logic        Fault
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_JALR     = 4'd11;
  localparam logic [3:0] S_FAULT    = 4'd15;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // One bit wider than the counter so the +1 compare cannot wrap at 255.
  localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT);

  logic [3:0] state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       fault_q, fault_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       mem_wait;
  logic       timeout_hit;
  logic       ir_write_raw;
  logic       pc_write_raw;
  logic       unused_instr_bits;

  assign opcode = Instr[6:0];
  assign funct3 = Instr[14:12];
  assign unused_instr_bits = ^{Instr[31:15], Instr[11:7]};

  // --------------------------------------------------------------------------
  // Output decode: a function of the current state, except for the FETCH
  // write pulses (qualified by MemReady) and the branch PC write (by Zero).
  // --------------------------------------------------------------------------
  always_comb begin
    MemReq       = 1'b0;
    MemWrite     = 1'b0;
    ir_write_raw = 1'b0;
    pc_write_raw = 1'b0;
    AdrSrc       = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    ImmSrc       = 3'b000;
    case (state_q)
      S_FETCH: begin
        MemReq       = 1'b1;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        ir_write_raw = MemReady;
        pc_write_raw = MemReady;
      end
      S_DECODE: begin
        // Branch target is precomputed here so BRANCH only has to compare.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b010;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (opcode == OP_STORE) ? 3'b001 : 3'b000;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        RegWrite  = 1'b1;
        ResultSrc = 2'b01;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        case (funct3)
          3'b000:  pc_write_raw = Zero;
          3'b001:  pc_write_raw = ~Zero;
          default: pc_write_raw = 1'b0;
        endcase
      end
      S_JAL: begin
        // PC takes the target from DECODE; ALU forms OldPC+4 for the link.
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        ImmSrc       = 3'b011;
        pc_write_raw = 1'b1;
      end
      S_JALR: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b01;
        pc_write_raw = 1'b1;
      end
      default: begin
        // FAULT and unused encodings: every control line stays low.
      end
    endcase
  end

  // Write strobes are suppressed while reset is held so an access that is
  // abandoned by reset cannot retire through the FETCH decode.
  assign IRWrite = ir_write_raw & rst_n;
  assign PCWrite = pc_write_raw & rst_n;
  assign State   = state_q;
  assign Fault   = fault_q;

  // --------------------------------------------------------------------------
  // Next state. A timeout only fires on a cycle without MemReady, so a ready
  // arriving on the last allowed cycle completes the access instead.
  // --------------------------------------------------------------------------
  assign mem_wait    = MemReq & ~MemReady;
  assign timeout_hit = mem_wait & (({1'b0, wait_q} + 9'd1) >= TIMEOUT_LIMIT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = S_FAULT;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_ALUWB;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FAULT;
    endcase
    if (timeout_hit) begin
      state_d = S_FAULT;
    end
  end

  // Wait counter tracks stalled request cycles within a single state visit.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = 8'd0;
    end else if (mem_wait) begin
      wait_d = wait_q + 8'd1;
    end
  end

  assign fault_d = fault_q | (state_d == S_FAULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter: TIMEOUT, 15, max wait cycles for MemReady before fault (1..255).
REQ-002 SHALL have ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Instr  in  32  instruction register contents (opcode [6:0], funct3 [14:12]).
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completion strobe.
- MemReq  out  1  memory access request.
- MemWrite  out  1  store qualifier.
- IRWrite  out  1  latch instruction register.
- PCWrite  out  1  PC update enable.
- AdrSrc  out  1  address select (0 = PC, 1 = ALUOut).
- RegWrite  out  1  register file write.
- ResultSrc  out  2  result mux select (00 ALUOut, 01 data, 10 ALUResult).
- ALUSrcA  out  2  A operand (00 PC, 01 OldPC, 10 rs1).
- ALUSrcB  out  2  B operand (00 rs2, 01 ImmExt, 10 const 4).
- ALUOp  out  2  00 add, 01 sub/compare, 10 funct-decoded.
- ImmSrc  out  3  immediate format (000 I, 001 S, 010 B, 011 J).
- State  out  4  current state encoding.
- Fault  out  1  sticky fault flag.

Function
REQ-003 SHALL implement Moore FSM, encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, FAULT 15.
REQ-004 FETCH SHALL drive MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; on MemReady=1 SHALL pulse IRWrite and PCWrite for that cycle and go to DECODE.
REQ-005 DECODE SHALL decode opcode in one cycle: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ImmSrc=010 (branch target precompute).
REQ-006 MEMADR SHALL use ImmSrc=000 (load) or 001 (store), ALUSrcA=10, ALUSrcB=01, ALUOp=00; next MEMREAD (load) or MEMWRITE (store).
REQ-007 MEMREAD SHALL drive MemReq=1, AdrSrc=1; on MemReady -> MEMWB; MEMWB SHALL drive RegWrite=1, ResultSrc=01, then -> FETCH.
REQ-008 MEMWRITE SHALL drive MemReq=1, MemWrite=1, AdrSrc=1; on MemReady -> FETCH.
REQ-009 EXECR SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECI same with ALUSrcB=01, ImmSrc=000; both -> ALUWB; ALUWB SHALL drive RegWrite=1, ResultSrc=00, then -> FETCH.
REQ-010 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00; PCWrite = Zero when funct3=000, ~Zero when funct3=001, 0 otherwise; -> FETCH.
REQ-011 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1, ImmSrc=011 -> ALUWB; JALR SHALL drive ALUSrcA=10, ALUSrcB=01, ImmSrc=000, ALUOp=00 -> JAL-equivalent writeback path (ALUWB with PCWrite=1 in JALR cycle).
REQ-012 Outputs not listed for a state SHALL be 0; MemReq, MemWrite, PCWrite, RegWrite, IRWrite SHALL never assert in FAULT.
REQ-013 A wait counter SHALL count consecutive cycles with MemReq=1 and MemReady=0; reaching TIMEOUT SHALL force FAULT next cycle; counter SHALL clear on state change.
REQ-014 MemReady asserted in a state with MemReq=0 SHALL be ignored.
REQ-015 MemReady=1 on the same edge the counter reaches TIMEOUT SHALL complete the access (ready wins).
REQ-016 FAULT SHALL be terminal: Fault=1, State=15 until reset.

Reset
REQ-017 rst_n=0 SHALL asynchronously force State=FETCH, wait counter=0, Fault=0; all outputs SHALL then reflect FETCH decode (MemReq=1).
REQ-018 Reset mid-access SHALL abandon the transaction; no IRWrite/PCWrite/RegWrite pulse SHALL occur from it.

Configuration
REQ-019 With ILLEGAL_TRAP_EN defined, unrecognised opcode in DECODE SHALL go to FAULT; without it, SHALL go to FETCH (NOP, no writes).

Verification
REQ-020 Instr=0x00A00093 (addi), MemReady=1 each request -> FETCH,DECODE,EXECI,ALUWB,FETCH; RegWrite=1 only in ALUWB.
REQ-021 lw 0x0040A103, MemReady delayed 3 cycles in MEMREAD -> MemReq held 4 cycles, MEMWB RegWrite=1, ResultSrc=01.
REQ-022 beq funct3=000 with Zero=1 -> PCWrite=1 in BRANCH; Zero=0 -> PCWrite=0; bne inverse.
REQ-023 MemReady held 0 in FETCH -> FAULT after 15 wait cycles, Fault=1 sticky; MemReady=1 on 15th -> DECODE instead.
REQ-024 Opcode 0x7F -> FAULT with ILLEGAL_TRAP_EN, FETCH without; rst_n pulse low mid-MEMWRITE -> State=0 immediately, MemWrite=0.
